ama_riscv_fetch: RTL
====================

# ama_riscv_fetch

Instruction fetch unit sitting directly upstream of the instruction cache. It owns the PC, issues one word-address request per cycle into the cache's core request channel and absorbs the cache's core response channel into a small instruction queue. It presents PC/instruction pairs to decode and handles redirects from execute by flushing queued and in-flight wrong-path instructions.

## Interface

- RESET_VECTOR, 'h0: byte address of the first fetch; must be 4-byte aligned.
- QDEPTH, 2: instruction queue entries; power of 2, at least 2.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_ic  rv_if.TX  CORE_ADDR_BUS_W  word-address request to icache; valid/data driven, ready sampled
- rsp_ic  rv_if.RX  CORE_DATA_BUS  instruction response from icache; ready is tied 1; cache never stalls on it
- redirect_valid  in  1  execute-stage taken branch/jump
- redirect_pc  in  CORE_ADDR_BUS_B  redirect target byte address; bits [1:0] ignored
- out_valid  out  1  queue head valid toward decode
- out_ready  in  1  decode accepts head
- out_inst  out  32  instruction at queue head
- out_pc  out  CORE_ADDR_BUS_B  byte PC of out_inst

## Operation

- FSM: F_RESET -> F_RUN; F_RESET lasts exactly one cycle after rst deasserts; F_RUN until next reset.
- Registers: pc_word (next word to request), queue of QDEPTH {pc, inst} entries, occupancy count, outstanding bit (0/1), drop bit, in-flight PC.
- Issue: req_ic.valid=1 in F_RUN when (count + outstanding - deq) < QDEPTH, where deq = out_valid & out_ready; req_ic.data = pc_word.
- Accept (req_ic.valid & req_ic.ready): pc_word <= pc_word + 1, modulo 2^CORE_ADDR_BUS_W; outstanding <= 1; in-flight PC <= pc_word.
- While the cache holds ready low (miss), valid and data stay stable.
- Cache holds at most one accepted-but-unanswered request; issue never stalls on outstanding alone, because the cache returns a response in the same cycle it accepts the next request.
- Response (rsp_ic.valid): clears outstanding unless a new accept occurs in the same cycle. Enqueues {in-flight PC<<2, rsp_ic.data} if drop=0. If drop=1, the response is discarded and drop is cleared.
- Enqueue and dequeue in the same cycle: count unchanged, pointers both advance and wrap modulo QDEPTH.
- Issue rule guarantees that an enqueue never occurs when full. A bench assertion checks this.
- Redirect (redirect_valid=1):
  - Queue flushed; count <= 0.
  - pc_word <= redirect_pc >> 2.
  - drop <= 1 if a request is outstanding after this cycle's events and its response has not arrived.
  - A response arriving in the redirect cycle is discarded.
  - An accept in the redirect cycle is also marked for drop.
  - req_ic.data retargets the cycle after, even if the previous valid was never accepted.
- out_valid = (count != 0) & !redirect_valid, so no wrong-path handshake occurs in the redirect cycle.
- out_inst/out_pc come from the queue head register, not bypassed from rsp_ic.

## Timing

- Reset values: req_ic.valid=0, req_ic.data=0, out_valid=0, out_inst=0, out_pc=0, count=0, outstanding=0, drop=0, pc_word=RESET_VECTOR>>2, state=F_RESET.
- First req_ic.valid is 1 cycle after rst deasserts (F_RESET cycle), with data=RESET_VECTOR>>2.
- Hit latency: accept at cycle N, rsp_ic.valid at N+1, out_valid at N+2.
- Steady-state throughput: 1 instruction/cycle with out_ready=1 and QDEPTH=2.
- Miss: out_valid gap equals the cache miss duration; order is preserved.
- Redirect at cycle R: request for the target is visible at R+1. The first target instruction is on out at R+3 on a hit, or later if the wrong-path response is still pending.
- Reset mid-operation: all state returns to reset values next edge; in-flight responses after reset are ignored because outstanding=0.

## Test plan

- Reset, icache always hits, out_ready=1 -> requests 0,1,2,3...; out_pc 0x0,0x4,0x8 on consecutive cycles starting 3 cycles after rst release.
- out_ready=0 for 5 cycles -> queue fills to 2, req_ic.valid drops; on release, in-order drain with no loss or duplicate.
- Miss on word 4 (ready low 6 cycles) -> req_ic.data held at 5 with valid; out delivers pc 0x10 then 0x14 after the miss completes.
- Redirect to 0x100 while word 7 is outstanding -> word 7 response discarded; out_valid=0 in cycle R; next out_pc=0x100, then 0x104.
- Redirect in same cycle as a response and a dequeue -> response dropped, queue empty, no handshake, next request data=redirect>>2.
- pc_word at max word address -> next request wraps to 0; reset asserted with outstanding=1 -> late response not enqueued, out_valid stays 0.

Source files
------------

// File: rtl/ama_riscv_fetch.sv
// Instruction fetch: owns the PC, streams word requests into the icache
// and buffers responses in a small queue toward decode.
module ama_riscv_fetch #(
  parameter int CORE_ADDR_BUS_B = 32,
  parameter int CORE_ADDR_BUS_W = CORE_ADDR_BUS_B - 2,
  parameter logic [CORE_ADDR_BUS_B-1:0] RESET_VECTOR = '0,
  parameter int QDEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       req_ic_valid,
  input  logic                       req_ic_ready,
  output logic [CORE_ADDR_BUS_W-1:0] req_ic_data,
  input  logic                       rsp_ic_valid,
  output logic                       rsp_ic_ready,
  input  logic [31:0]                rsp_ic_data,
  input  logic                       redirect_valid,
  input  logic [CORE_ADDR_BUS_B-1:0] redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [CORE_ADDR_BUS_B-1:0] out_pc
);

  localparam int QW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic {F_RESET, F_RUN} state_t;

  state_t state, state_nx;

  logic [CORE_ADDR_BUS_W-1:0] pc_word;
  logic [CORE_ADDR_BUS_W-1:0] inflight;
  logic [31:0]                q_inst [QDEPTH];
  logic [CORE_ADDR_BUS_B-1:0] q_pc [QDEPTH];
  logic [QW-1:0]              wptr;
  logic [QW-1:0]              rptr;
  logic [CW-1:0]              count;
  logic                       outstanding;
  logic                       drop;

  logic          run;
  logic          accept;
  logic          rsp;
  logic          enq;
  logic          deq;
  logic [CW:0]   occ;
  logic          unused_lsb;

  assign unused_lsb   = ^redirect_pc[1:0];
  assign rsp_ic_ready = 1'b1;
  assign out_inst     = q_inst[rptr];
  assign out_pc       = q_pc[rptr];

  always_comb begin
    state_nx = state;
    run      = 1'b0;
    unique case (state)
      F_RESET: state_nx = F_RUN;
      F_RUN:   run = 1'b1;
      default: state_nx = F_RESET;
    endcase
    out_valid    = (count != '0) & ~redirect_valid;
    deq          = out_valid & out_ready;
    // slots already promised: queued + in flight - leaving now
    occ          = {1'b0, count} + (CW+1)'(outstanding)
                   - (CW+1)'(deq);
    req_ic_valid = run & (occ < (CW+1)'(QDEPTH));
    req_ic_data  = run ? pc_word : '0;
    accept       = req_ic_valid & req_ic_ready;
    rsp          = rsp_ic_valid & outstanding;
    enq          = rsp & ~drop & ~redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= F_RESET;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_word     <= RESET_VECTOR[CORE_ADDR_BUS_B-1:2];
      inflight    <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      if (accept) begin
        pc_word  <= pc_word + CORE_ADDR_BUS_W'(1);
        inflight <= pc_word;
      end
      if (accept)   outstanding <= 1'b1;
      else if (rsp) outstanding <= 1'b0;
      if (redirect_valid) begin
        pc_word <= redirect_pc[CORE_ADDR_BUS_B-1:2];
        wptr    <= '0;
        rptr    <= '0;
        count   <= '0;
        drop    <= accept | (outstanding & ~rsp);
      end else begin
        if (rsp && drop) drop <= 1'b0;
        if (enq) begin
          q_inst[wptr] <= rsp_ic_data;
          q_pc[wptr]   <= {inflight, 2'b00};
          wptr         <= wptr + QW'(1);
        end
        if (deq) rptr <= rptr + QW'(1);
        unique case ({enq, deq})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
